// File: rtl/switch_pkg.sv
// Shared definitions for the voq_switch core: slot phases, default cell type
// and the helper that sizes port-index fields.
package switch_pkg;

  localparam int CELL_W_DEFAULT = 32;

  // Slot phases: grants are decided in SLOT_MATCH and cells move in SLOT_XFER.
  localparam int SLOT_MATCH = 0;
  localparam int SLOT_XFER  = 1;

  typedef logic [CELL_W_DEFAULT-1:0] cell_t;

  // Width of a port index; never narrower than one bit.
  function automatic int port_idx_w(input int nports);
    return (nports > 1) ? $clog2(nports) : 1;
  endfunction

endpackage

// File: rtl/voq_switch_if.sv
// Host-side bundle of the voq_switch: ingress cells with ready, VOQ status,
// and egress holding registers with ack. Flattened per-port vectors.
interface voq_switch_if #(
  parameter int NPORTS = 4,
  parameter int DATA_W = 32
);
  import switch_pkg::*;

  localparam int PW = port_idx_w(NPORTS);

  logic [NPORTS-1:0]        in_valid;
  logic [NPORTS*PW-1:0]     in_dest;
  logic [NPORTS*DATA_W-1:0] in_data;
  logic [NPORTS-1:0]        in_ready;
  logic [NPORTS*NPORTS-1:0] voq_empty;
  logic [NPORTS-1:0]        out_valid;
  logic [NPORTS*DATA_W-1:0] out_data;
  logic [NPORTS*PW-1:0]     out_src;
  logic [NPORTS-1:0]        out_ack;

  modport master (
    output in_valid, in_dest, in_data, out_ack,
    input  in_ready, voq_empty, out_valid, out_data, out_src
  );

  modport slave (
    input  in_valid, in_dest, in_data, out_ack,
    output in_ready, voq_empty, out_valid, out_data, out_src
  );

endinterface

// File: rtl/voq_fifo.sv
// Single synchronous FIFO used for one virtual output queue. Push when full
// and pop when empty are ignored. Storage is not reset; pointers are.
module voq_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Cell storage write.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/voq_switch.sv
// voq_switch: N-port cell switch with per-input VOQs, a slot-timed
// round-robin matcher and per-output holding registers with ack.
// Optional feature macro: SWITCH_STATS_EN adds stat_delivered/stat_refused.
module voq_switch
  import switch_pkg::*;
#(
  parameter int NPORTS      = 4,
  parameter int DATA_W      = 32,
  parameter int VOQ_DEPTH   = 4,
  parameter int SLOT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              experimenting,
  voq_switch_if.slave       bus
`ifdef SWITCH_STATS_EN
  ,
  output logic [NPORTS*32-1:0] stat_delivered,
  output logic [NPORTS*32-1:0] stat_refused
`endif
);

  localparam int PW = port_idx_w(NPORTS);
  localparam int SW = $clog2(SLOT_CYCLES);

  typedef logic [PW-1:0] pidx_t;

  logic [SW-1:0]     slot;
  pidx_t             rr_ptr;
  pidx_t             in_ptr    [NPORTS];
  pidx_t             in_dest   [NPORTS];

  logic              push      [NPORTS][NPORTS];
  logic              pop       [NPORTS][NPORTS];
  logic              fifo_empty[NPORTS][NPORTS];
  logic              fifo_full [NPORTS][NPORTS];
  logic [DATA_W-1:0] head      [NPORTS][NPORTS];

  logic [NPORTS-1:0] match_vld;
  pidx_t             match_dst [NPORTS];
  logic [NPORTS-1:0] grant_vld;
  pidx_t             grant_dst [NPORTS];

  logic [NPORTS-1:0] load_vld;
  pidx_t             load_src  [NPORTS];
  logic [DATA_W-1:0] load_data [NPORTS];

  logic [NPORTS-1:0] out_vld_q;
  logic [DATA_W-1:0] out_data_q[NPORTS];
  pidx_t             out_src_q [NPORTS];

  logic              in_match;
  logic              in_xfer;

  assign in_match = (slot == SW'(SLOT_MATCH));
  assign in_xfer  = (slot == SW'(SLOT_XFER));

  // VOQ array: queue [i][j] holds cells from input i bound for output j.
  for (genvar i = 0; i < NPORTS; i++) begin : g_in
    assign in_dest[i]     = bus.in_dest[i*PW +: PW];
    // Ready uses pre-dequeue occupancy, so a full VOQ refuses even on a pop cycle.
    assign bus.in_ready[i] = !fifo_full[i][in_dest[i]];
    for (genvar j = 0; j < NPORTS; j++) begin : g_out
      assign push[i][j] = bus.in_valid[i] && bus.in_ready[i] && (in_dest[i] == PW'(j));
      assign pop[i][j]  = in_xfer && grant_vld[i] && (grant_dst[i] == PW'(j));
      assign bus.voq_empty[i*NPORTS+j] = fifo_empty[i][j];

      voq_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (VOQ_DEPTH)
      ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push[i][j]),
        .pop       (pop[i][j]),
        .push_data (bus.in_data[i*DATA_W +: DATA_W]),
        .head      (head[i][j]),
        .empty     (fifo_empty[i][j]),
        .full      (fifo_full[i][j])
      );
    end
  end

  // Output holding registers presented on the bus.
  for (genvar j = 0; j < NPORTS; j++) begin : g_hold
    assign bus.out_valid[j]                  = out_vld_q[j];
    assign bus.out_data[j*DATA_W +: DATA_W]  = out_data_q[j];
    assign bus.out_src[j*PW +: PW]           = out_src_q[j];
  end

  // Slot counter, free-running regardless of experimenting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot <= '0;
    end else if (slot == SW'(SLOT_CYCLES-1)) begin
      slot <= '0;
    end else begin
      slot <= slot + 1'b1;
    end
  end

  // Round-robin matcher: inputs from rr_ptr, each scanning outputs from its own
  // pointer; busy outputs and outputs already claimed this slot are skipped.
  always_comb begin
    pidx_t ii;
    pidx_t jj;
    logic [NPORTS-1:0] claimed;
    ii        = '0;
    jj        = '0;
    claimed   = '0;
    match_vld = '0;
    for (int i = 0; i < NPORTS; i++) match_dst[i] = '0;
    if (in_match && experimenting) begin
      for (int k = 0; k < NPORTS; k++) begin
        ii = rr_ptr + PW'(k);
        for (int m = 0; m < NPORTS; m++) begin
          jj = in_ptr[ii] + PW'(m);
          if (!match_vld[ii] && !fifo_empty[ii][jj] && !claimed[jj] && !out_vld_q[jj]) begin
            match_vld[ii] = 1'b1;
            match_dst[ii] = jj;
            claimed[jj]   = 1'b1;
          end
        end
      end
    end
  end

  // Grant register: captured at the end of the match phase, retired after transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_vld <= '0;
      for (int i = 0; i < NPORTS; i++) grant_dst[i] <= '0;
    end else if (in_match) begin
      grant_vld <= match_vld;
      grant_dst <= match_dst;
    end else if (in_xfer) begin
      grant_vld <= '0;
    end
  end

  // Fairness pointers advance only at the transfer edge and only for real grants.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
      for (int i = 0; i < NPORTS; i++) in_ptr[i] <= '0;
    end else if (in_xfer) begin
      for (int i = 0; i < NPORTS; i++) begin
        if (grant_vld[i]) in_ptr[i] <= grant_dst[i] + 1'b1;
      end
      if (|grant_vld) rr_ptr <= rr_ptr + 1'b1;
    end
  end

  // Crossbar: route each granted VOQ head to its output during the transfer phase.
  always_comb begin
    load_vld = '0;
    for (int j = 0; j < NPORTS; j++) begin
      load_src[j]  = '0;
      load_data[j] = '0;
    end
    if (in_xfer) begin
      for (int j = 0; j < NPORTS; j++) begin
        for (int i = 0; i < NPORTS; i++) begin
          if (grant_vld[i] && (grant_dst[i] == PW'(j))) begin
            load_vld[j]  = 1'b1;
            load_src[j]  = PW'(i);
            load_data[j] = head[i][j];
          end
        end
      end
    end
  end

  // Holding registers: load from the crossbar, clear valid on ack; data/src persist.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_vld_q <= '0;
      for (int j = 0; j < NPORTS; j++) begin
        out_data_q[j] <= '0;
        out_src_q[j]  <= '0;
      end
    end else begin
      for (int j = 0; j < NPORTS; j++) begin
        if (load_vld[j]) begin
          out_vld_q[j]  <= 1'b1;
          out_data_q[j] <= load_data[j];
          out_src_q[j]  <= load_src[j];
        end else if (bus.out_ack[j]) begin
          out_vld_q[j]  <= 1'b0;
        end
      end
    end
  end

`ifdef SWITCH_STATS_EN
  logic [31:0] delivered [NPORTS];
  logic [31:0] refused   [NPORTS];

  for (genvar j = 0; j < NPORTS; j++) begin : g_stat
    assign stat_delivered[j*32 +: 32] = delivered[j];
    assign stat_refused[j*32 +: 32]   = refused[j];
  end

  // Per-port counters of acked cells and refused offer cycles, wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < NPORTS; j++) begin
        delivered[j] <= '0;
        refused[j]   <= '0;
      end
    end else begin
      for (int j = 0; j < NPORTS; j++) begin
        if (bus.out_ack[j] && out_vld_q[j])      delivered[j] <= delivered[j] + 32'd1;
        if (bus.in_valid[j] && !bus.in_ready[j]) refused[j]   <= refused[j] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/voq_switch.md
# voq_switch

Parametrised N-port fixed-length-cell switch core: per-input virtual output queues (VOQs), a slot-timed round-robin matcher and an N×N crossbar feeding per-output holding registers with ack handshake. Successor to the fixed 4-port switch; generalises port count, cell width, VOQ depth and slot length, and adds backpressure, fair round-robin matching and output-busy exclusion. Sits between the host interface (ingress cells, egress acks) and the egress drain logic.

## Interface
- NPORTS, 4, port count; power of two, ≥2; PW = $clog2(NPORTS)
- DATA_W, 32, cell width (one cell = one word)
- VOQ_DEPTH, 4, cells per VOQ; power of two, ≥2
- SLOT_CYCLES, 16, cycles per scheduling slot; ≥2
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-high
- experimenting  in  1  scheduling enable
- in_valid  in  NPORTS  cell offered on input i
- in_dest  in  NPORTS*PW  destination output per input
- in_data  in  NPORTS*DATA_W  cell per input
- in_ready  out  NPORTS  input i accepts cell this cycle
- voq_empty  out  NPORTS*NPORTS  bit i*NPORTS+j = VOQ[i][j] empty
- out_valid  out  NPORTS  output holding register occupied
- out_data  out  NPORTS*DATA_W  held cell
- out_src  out  NPORTS*PW  source input of held cell
- out_ack  in  NPORTS  consume held cell

## Operation
- Enqueue: in_valid[i] && in_ready[i] writes in_data[i] into VOQ[i][in_dest[i]] at the clock edge. in_ready[i] = !full(VOQ[i][in_dest[i]]), computed from pre-dequeue occupancy (a full VOQ refuses even when dequeued the same cycle).
- Slot counter `slot` counts 0..SLOT_CYCLES-1, wraps to 0; runs regardless of experimenting.
- Matching (slot==0, experimenting=1): inputs visited starting at global pointer rr_ptr, then rr_ptr+1, … mod NPORTS. Each input scans outputs from its own pointer in_ptr[i], granting the first j with VOQ[i][j] non-empty, output j unclaimed this slot and out_valid[j]=0. At most one grant per input and per output. Grants registered at the edge ending slot 0.
- Transfer (slot==1): each granted VOQ pops its head into out_data[j]; out_valid[j]←1, out_src[j]←i.
- Pointer update at the transfer edge: in_ptr[i]←(granted j+1) mod NPORTS for granted inputs only; rr_ptr←rr_ptr+1 mod NPORTS if any grant, else unchanged.
- out_ack[j] with out_valid[j]=1 clears out_valid[j] next edge; out_data/out_src hold their value. Ack with out_valid=0 ignored.
- experimenting=0: no grants; enqueue and ack still operate. Dropping experimenting after slot 0 does not cancel the registered grant.
- Reset: all VOQs empty, in_ready all 1, voq_empty all 1, out_valid/out_data/out_src 0, slot, rr_ptr, in_ptr all 0, grants cleared. Reset mid-slot discards queued and held cells.

## Timing
- Cell enqueued at an edge before slot 0 is eligible at that slot's match; voq_empty updates the cycle after enqueue/pop.
- Match→out_valid: out_valid high from the first cycle of slot 2 (2 edges after slot 0 starts).
- Output busy at slot-0 decision is excluded for the whole slot, even if acked during slot 1.
- Ack and load never target the same register in one cycle (excluded by construction).
- Throughput: ≤1 cell per input and per output per slot.

## Configuration
- SWITCH_STATS_EN defined: adds output stat_delivered (NPORTS*32) — per-output count of acked cells, wrapping at 2^32, and stat_refused (NPORTS*32) — per-input count of cycles with in_valid=1, in_ready=0; both reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Package switch_pkg: port_idx_t width helper, cell_t typedef parametrised via DATA_W default, localparams for slot phases (SLOT_MATCH=0, SLOT_XFER=1).
- Sub-module voq_fifo: single synchronous FIFO (push, pop, head data, empty, full, DEPTH param), instantiated NPORTS² times via generate.
- Matcher is combinational logic inside voq_switch.

## Test plan
- Reset → in_ready=4'hF, voq_empty all 1, out_valid=0, slot=0.
- Input 0 pushes 0xA5 to dest 2, experimenting=1 → out_valid[2]=1, out_data[2]=0xA5, out_src[2]=0 at slot 2; voq_empty bit 2 returns 1.
- Inputs 0 and 1 both target output 3, no acks until end → over two slots (with ack between) output 3 delivers input 0 cell then input 1 cell (rr_ptr fairness).
- Push VOQ_DEPTH=4 cells 0..3 into VOQ[1][0], experimenting=0 → in_ready[1] low with in_dest=0, high with in_dest=1; after enabling, cells emerge in order 0,1,2,3 with one ack per slot.
- out_valid[0] held without ack while VOQ[2][0] non-empty → no grant to output 0 for that slot; after ack next slot delivers.
- With SWITCH_STATS_EN: 5 acked cells on output 1 → stat_delivered[1]=5; 3 refused cycles on input 1 → stat_refused[1]=3.
